// File: rtl/siso_shift_reg_if.sv
// Serial bit-stream interface for siso_shift_reg.
// The taps bus is present only when SISO_TAPS_EN is defined.
interface siso_shift_reg_if #(
    parameter int DEPTH = 4
);
    logic in;
    logic shift;
    logic out;
    logic primed;
`ifdef SISO_TAPS_EN
    logic [DEPTH-1:0] taps;

    modport master (output in, output shift, input out, input primed, input taps);
    modport slave  (input in, input shift, output out, output primed, output taps);
`else
    modport master (output in, output shift, input out, input primed);
    modport slave  (input in, input shift, output out, output primed);
`endif
endinterface

// File: rtl/siso_shift_reg.sv
// Serial-in/serial-out bit-delay line of DEPTH enabled stages with a primed flag.
// Optional feature macro: SISO_TAPS_EN exposes the full register as bus.taps.
module siso_shift_reg #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    siso_shift_reg_if.slave  bus
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if ((DEPTH < 1) || (DEPTH > 64)) begin : g_depth_check
        $error("siso_shift_reg: DEPTH out of range 1..64");
    end

    logic [DEPTH-1:0] sr_r;
    logic [DEPTH-1:0] sr_next_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             primed_r;

    // The fill counter stops at DEPTH so primed can never drop back before reset.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == FULL) begin
            return c;
        end else begin
            return c + CW'(1);
        end
    endfunction

    // Next-state for the stage chain and fill counter on an enabled edge.
    always_comb begin
        sr_next_s    = sr_r;
        count_next_s = count_r;
        if (bus.shift) begin
            sr_next_s[0] = bus.in;
            for (int i = 1; i < DEPTH; i++) begin
                sr_next_s[i] = sr_r[i-1];
            end
            count_next_s = sat_inc(count_r);
        end else begin
            sr_next_s    = sr_r;
            count_next_s = count_r;
        end
    end

    // State registers; primed is registered from the next count so it aligns with out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r     <= {DEPTH{1'b0}};
            count_r  <= {CW{1'b0}};
            primed_r <= 1'b0;
        end else begin
            sr_r     <= sr_next_s;
            count_r  <= count_next_s;
            primed_r <= (count_next_s == FULL);
        end
    end

    assign bus.out    = sr_r[DEPTH-1];
    assign bus.primed = primed_r;
`ifdef SISO_TAPS_EN
    assign bus.taps   = sr_r;
`endif

endmodule

// File: tb/tb_siso_shift_reg.sv
// Self-checking bench: directed vector table for DEPTH=4, hand sequence for DEPTH=1,
// then randomized traffic on both depths against a queue-based reference model.
module tb_siso_shift_reg;
    logic clk = 1'b0;
    logic rst4;
    logic rst1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    siso_shift_reg_if #(.DEPTH(4)) if4 ();
    siso_shift_reg_if #(.DEPTH(1)) if1 ();

    siso_shift_reg #(.DEPTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
    siso_shift_reg #(.DEPTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    typedef struct {
        bit       rst;
        bit       shift;
        bit       din;
        bit       exp_out;
        bit       exp_primed;
        bit [3:0] exp_taps;
    } vec_t;

    vec_t tbl[$];

    // reference model state: bits accepted since reset, newest at the back
    bit q4[$];
    bit q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit s, bit d, bit o, bit p, bit [3:0] t);
        vec_t v;
        v.rst = r; v.shift = s; v.din = d;
        v.exp_out = o; v.exp_primed = p; v.exp_taps = t;
        return v;
    endfunction

    // Model one edge: reset empties history, an enabled edge appends in.
    task automatic model_step(input int depth, input bit r, input bit s, input bit d,
                              inout bit q[$]);
        if (r) begin
            q.delete();
        end else if (s) begin
            q.push_back(d);
            if (q.size() > depth) void'(q.pop_front());
        end
    endtask

    function automatic bit model_tap(input bit q[$], input int i);
        if (i < q.size()) return q[q.size()-1-i];
        return 1'b0;
    endfunction

    initial begin
        rst4 = 1'b1; rst1 = 1'b1;
        if4.in = 1'b0; if4.shift = 1'b0;
        if1.in = 1'b0; if1.shift = 1'b0;

        // 1: reset
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'b0000));
        // 2: fill with ones
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0111));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1111));
        // 3: drain with zeros
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'b1110));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'b1100));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'b1000));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0000));
        // 4: pattern 1,0,1,1 then hold with in toggling
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0001));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'b0010));
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0101));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4'b1011));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'b1011));
        // 5: two shifts, mid-stream reset (rst beats shift), refill
        tbl.push_back(mk(0, 1, 1, 0, 1, 4'b0111));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1111));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0011));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0111));
        tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1111));

        #2;
        for (int k = 0; k < tbl.size(); k++) begin
            rst4 = tbl[k].rst; if4.shift = tbl[k].shift; if4.in = tbl[k].din;
            @(posedge clk); #1;
            check($sformatf("vec%0d_out", k), {63'd0, if4.out}, {63'd0, tbl[k].exp_out});
            check($sformatf("vec%0d_primed", k), {63'd0, if4.primed}, {63'd0, tbl[k].exp_primed});
`ifdef SISO_TAPS_EN
            check($sformatf("vec%0d_taps", k), {60'd0, if4.taps}, {60'd0, tbl[k].exp_taps});
`endif
        end

        // 6: DEPTH=1 follows in one edge later, primed after first shift
        rst1 = 1'b1; if1.shift = 1'b1; if1.in = 1'b1;
        @(posedge clk); #1;
        check("d1_rst_out", {63'd0, if1.out}, 64'd0);
        check("d1_rst_primed", {63'd0, if1.primed}, 64'd0);
        rst1 = 1'b0; if1.in = 1'b1;
        @(posedge clk); #1;
        check("d1_s1_out", {63'd0, if1.out}, 64'd1);
        check("d1_s1_primed", {63'd0, if1.primed}, 64'd1);
        if1.in = 1'b0;
        @(posedge clk); #1;
        check("d1_s2_out", {63'd0, if1.out}, 64'd0);
        if1.in = 1'b1;
        @(posedge clk); #1;
        check("d1_s3_out", {63'd0, if1.out}, 64'd1);
        if1.shift = 1'b0; if1.in = 1'b0;
        @(posedge clk); #1;
        check("d1_hold_out", {63'd0, if1.out}, 64'd1);
        check("d1_hold_primed", {63'd0, if1.primed}, 64'd1);

        // randomized traffic on both depths, starting from reset
        rst4 = 1'b1; rst1 = 1'b1; if4.shift = 1'b0; if1.shift = 1'b0;
        @(posedge clk); #1;
        q4.delete(); q1.delete();
        for (int n = 0; n < 400; n++) begin
            bit r4, s4, d4, r1, s1, d1;
            r4 = ($urandom_range(0, 31) == 0);
            s4 = ($urandom_range(0, 3) != 0);
            d4 = 1'($urandom);
            r1 = ($urandom_range(0, 31) == 0);
            s1 = ($urandom_range(0, 3) != 0);
            d1 = 1'($urandom);
            rst4 = r4; if4.shift = s4; if4.in = d4;
            rst1 = r1; if1.shift = s1; if1.in = d1;
            @(posedge clk);
            model_step(4, r4, s4, d4, q4);
            model_step(1, r1, s1, d1, q1);
            #1;
            check("rnd4_out", {63'd0, if4.out}, {63'd0, model_tap(q4, 3)});
            check("rnd4_primed", {63'd0, if4.primed}, {63'd0, (q4.size() == 4)});
            check("rnd1_out", {63'd0, if1.out}, {63'd0, model_tap(q1, 0)});
            check("rnd1_primed", {63'd0, if1.primed}, {63'd0, (q1.size() == 1)});
`ifdef SISO_TAPS_EN
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rnd4_tap%0d", i), {63'd0, if4.taps[i]}, {63'd0, model_tap(q4, i)});
            end
            check("rnd1_tap0", {63'd0, if1.taps[0]}, {63'd0, model_tap(q1, 0)});
`endif
            // glitch on in between edges must not matter
            if4.in = ~if4.in; if1.in = ~if1.in;
            #2;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
